// File: rtl/mfp_srec_write_combiner_ahb_bridge.sv
// ============================================================================
//  mfp_srec_write_combiner_ahb_bridge
//  Merges SREC parser bytes into aligned words and writes them over AHB-Lite.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mfp_srec_write_combiner_ahb_bridge #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IDLE_CYCLES = 256,
    parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        big_endian,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    input  logic        flush,
    output logic        busy,
    output logic        overflow,
    output logic        bus_error,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

    // ---------------- combine buffer ----------------
    logic             buf_valid_q, buf_valid_d;
    entry_t           buf_q, buf_d, push_entry, merged;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             push;
    logic [1:0]       lane;
    logic [3:0]       lane_bit;
    logic [31:0]      byte_data;

    always_comb begin
        lane        = big_endian ? ~write_address[1:0] : write_address[1:0];
        lane_bit    = 4'b0001 << lane;
        byte_data   = {24'b0, write_byte} << {lane, 3'b000};
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        push        = 1'b0;
        push_entry  = buf_q;
        merged      = buf_q;
        merged.data = buf_q.data | byte_data;
        merged.mask = buf_q.mask | lane_bit;

        // Explicit flush or idle timeout drains the old word before any new byte lands.
        if (buf_valid_q && (flush || idle_cnt_q == IDLE_LAST)) begin
            push        = 1'b1;
            buf_valid_d = 1'b0;
        end

        if (write_enable) begin
            if (!buf_valid_d) begin
                buf_valid_d = 1'b1;
                buf_d       = '{waddr: write_address[31:2], data: byte_data, mask: lane_bit};
            end else if (buf_q.waddr == write_address[31:2] && (buf_q.mask & lane_bit) == 4'b0) begin
                if (merged.mask == 4'hF) begin
                    push        = 1'b1;
                    push_entry  = merged;
                    buf_valid_d = 1'b0;
                end else begin
                    buf_d = merged;
                end
            end else begin
                push        = 1'b1;
                buf_valid_d = 1'b1;
                buf_d       = '{waddr: write_address[31:2], data: byte_data, mask: lane_bit};
            end
        end

        idle_cnt_d = (write_enable || !buf_valid_q) ? '0 : idle_cnt_q + CNT_W'(1);
    end

    // ---------------- entry FIFO ----------------
    entry_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           fifo_empty, fifo_full, pop, accept;
    entry_t         head;
    state_t         state_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign accept     = push && (!fifo_full || pop);

    always_ff @(posedge clock) begin
        if (accept) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_entry;
        end
    end

    logic overflow_q, busy_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            idle_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            idle_cnt_q  <= idle_cnt_d;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !accept) overflow_q <= 1'b1;
            busy_q      <= buf_valid_q || !fifo_empty || (state_q != S_IDLE);
        end
    end

    // ---------------- AHB master ----------------
    entry_t      work_q;
    logic [31:0] haddr_q, hwdata_q;
    logic [2:0]  hsize_q;
    logic [1:0]  htrans_q;
    logic        bus_error_q;
    logic [3:0]  rem_mask, src_mask;
    logic [29:0] src_waddr;
    logic [1:0]  low_lane;
    logic [31:0] a_haddr;
    logic [2:0]  a_hsize;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Address-phase attributes for either a freshly popped entry or the remainder of the working one.
    always_comb begin
        rem_mask  = (work_q.mask == 4'hF) ? 4'h0
                  : work_q.mask & ~(4'b0001 << lowest_lane(work_q.mask));
        src_mask  = (state_q == S_IDLE) ? head.mask  : rem_mask;
        src_waddr = (state_q == S_IDLE) ? head.waddr : work_q.waddr;
        low_lane  = lowest_lane(src_mask);
        if (src_mask == 4'hF) begin
            a_haddr = {src_waddr, 2'b00};
            a_hsize = 3'b010;
        end else begin
            a_haddr = {src_waddr, big_endian ? ~low_lane : low_lane};
            a_hsize = 3'b000;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            haddr_q     <= '0;
            hsize_q     <= '0;
            htrans_q    <= 2'b00;
            hwdata_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        work_q   <= head;
                        haddr_q  <= a_haddr;
                        hsize_q  <= a_hsize;
                        htrans_q <= 2'b10;
                        state_q  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (HREADY) begin
                        htrans_q <= 2'b00;
                        hwdata_q <= work_q.data;
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (HREADY) begin
                        if (HRESP) bus_error_q <= 1'b1;
                        work_q.mask <= rem_mask;
                        if (rem_mask != 4'h0) begin
                            haddr_q  <= a_haddr;
                            hsize_q  <= a_hsize;
                            htrans_q <= 2'b10;
                            state_q  <= S_ADDR;
                        end else begin
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign bus_error = bus_error_q;
    assign HADDR     = haddr_q;
    assign HSIZE     = hsize_q;
    assign HTRANS    = htrans_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VALUE;
    assign HWRITE    = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_mfp_srec_write_combiner_ahb_bridge.sv
// ============================================================================
//  tb_mfp_srec_write_combiner_ahb_bridge
//  Scoreboard bench: byte-level reference model predicts AHB transfers.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mfp_srec_write_combiner_ahb_bridge;

    localparam int DEPTH = 4;
    localparam int IDLE  = 16;

    logic        clock = 1'b0, reset = 1'b1, big_endian = 1'b0;
    logic [31:0] write_address = '0;
    logic [7:0]  write_byte = '0;
    logic        write_enable = 1'b0, flush = 1'b0;
    logic        busy, overflow, bus_error, HMASTLOCK, HWRITE;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HBURST, HSIZE;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    mfp_srec_write_combiner_ahb_bridge #(
        .FIFO_DEPTH(DEPTH), .IDLE_CYCLES(IDLE), .HPROT_VALUE(4'b0011)
    ) dut (
        .clock(clock), .reset(reset), .big_endian(big_endian),
        .write_address(write_address), .write_byte(write_byte),
        .write_enable(write_enable), .flush(flush),
        .busy(busy), .overflow(overflow), .bus_error(bus_error),
        .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } xfer_t;
    xfer_t exp_q[$];

    // 0: always ready, 1: random, 2: hready_val
    int   hready_mode = 0;
    logic hready_val = 1'b1, hresp_val = 1'b0;

    always @(posedge clock) begin
        #2;
        case (hready_mode)
            0:       HREADY = 1'b1;
            1:       HREADY = ($urandom % 4) != 0;
            default: HREADY = hready_val;
        endcase
        HRESP = hresp_val;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    logic        mb_valid = 1'b0;
    logic [29:0] mb_waddr = '0;
    logic [7:0]  mb_bytes [4];
    logic [3:0]  mb_mask = '0;
    int          m_idle = 0;
    logic        exp_bus_error = 1'b0;

    function automatic logic [31:0] pack_word(input logic [3:0] m);
        logic [31:0] w = '0;
        for (int l = 0; l < 4; l++)
            if (m[l]) w[8*l +: 8] = mb_bytes[l];
        return w;
    endfunction

    task automatic emit_entry();
        xfer_t x;
        x.data = pack_word(mb_mask);
        if (mb_mask == 4'hF) begin
            x.addr = {mb_waddr, 2'b00};
            x.size = 3'd2;
            exp_q.push_back(x);
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (mb_mask[l]) begin
                    x.addr = {mb_waddr, big_endian ? 2'(3 - l) : 2'(l)};
                    x.size = 3'd0;
                    exp_q.push_back(x);
                end
            end
        end
    endtask

    task automatic model_cycle(input logic we, input logic [31:0] a, input logic [7:0] d, input logic fl);
        int  ln;
        logic was_valid = mb_valid;
        ln = big_endian ? 3 - int'(a[1:0]) : int'(a[1:0]);
        if (mb_valid && (fl || m_idle == IDLE - 1)) begin
            emit_entry();
            mb_valid = 1'b0;
        end
        if (we) begin
            if (mb_valid && mb_waddr == a[31:2] && !mb_mask[ln]) begin
                mb_bytes[ln] = d;
                mb_mask[ln]  = 1'b1;
                if (mb_mask == 4'hF) begin
                    emit_entry();
                    mb_valid = 1'b0;
                end
            end else begin
                if (mb_valid) emit_entry();
                mb_valid = 1'b1;
                mb_waddr = a[31:2];
                mb_mask  = '0;
                for (int l = 0; l < 4; l++) mb_bytes[l] = 8'h00;
                mb_bytes[ln] = d;
                mb_mask[ln]  = 1'b1;
            end
        end
        m_idle = (we || !was_valid) ? 0 : m_idle + 1;
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [7:0] d, input logic fl);
        write_enable  = we;
        write_address = a;
        write_byte    = d;
        flush         = fl;
        model_cycle(we, a, d, fl);
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        write_enable = 1'b0;
        flush = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        mb_valid = 1'b0;
        m_idle = 0;
        exp_bus_error = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mb_valid || busy) && n < 3000) begin
            step(1'b0, '0, '0, 1'b0);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_drain actual_pending=%0d expected_pending=0", name, exp_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    logic        in_data = 1'b0;
    logic [31:0] cap_addr;
    logic [2:0]  cap_size;
    xfer_t       mon_e;

    always @(negedge clock) begin
        if (reset) begin
            in_data = 1'b0;
        end else if (in_data) begin
            chk("dphase_htrans", {30'b0, HTRANS}, 32'd0);
            if (HREADY) begin
                if (HRESP) exp_bus_error = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected actual_addr=%h expected=none", cap_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("xfer_addr", cap_addr, mon_e.addr);
                    chk("xfer_size", {29'b0, cap_size}, {29'b0, mon_e.size});
                    chk("xfer_data", HWDATA, mon_e.data);
                end
                in_data = 1'b0;
            end
        end else if (HTRANS == 2'b10 && HREADY) begin
            cap_addr = HADDR;
            cap_size = HSIZE;
            in_data  = 1'b1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          k;
        logic [31:0] a0, d0;
        logic [2:0]  s0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_htrans", {30'b0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_flags", {29'b0, busy, overflow, bus_error}, 32'd0);
        chk("const_ctrl", {20'b0, HBURST, HMASTLOCK, HPROT, HWRITE, 3'b0}, {20'b0, 3'b000, 1'b0, 4'b0011, 1'b1, 3'b0});

        // full word, little then big endian
        for (int be = 0; be < 2; be++) begin
            big_endian = 1'(be);
            step(1'b1, 32'h0, 8'h11, 1'b0);
            step(1'b1, 32'h1, 8'h22, 1'b0);
            step(1'b1, 32'h2, 8'h33, 1'b0);
            step(1'b1, 32'h3, 8'h44, 1'b0);
            drain(be ? "be_word" : "le_word");
            chk("word_overflow", {31'b0, overflow}, 32'd0);
        end

        // partial word via flush, then via idle timeout
        big_endian = 1'b0;
        step(1'b1, 32'h10005, 8'hAB, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        drain("flush_byte");
        step(1'b1, 32'h10005, 8'hAB, 1'b0);
        k = 0;
        while (HTRANS != 2'b10 && k < 100) begin
            step(1'b0, '0, '0, 1'b0);
            k++;
        end
        checks++;
        if (k < IDLE || k > IDLE + 2) begin
            errors++;
            $display("FAIL idle_flush_latency actual=%0d expected=%0d..%0d", k, IDLE, IDLE + 2);
        end
        drain("idle_byte");

        // word changes force pushes
        step(1'b1, 32'h0, 8'hA0, 1'b0);
        step(1'b1, 32'h8, 8'hA1, 1'b0);
        step(1'b1, 32'h1, 8'hA2, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        drain("word_change");

        // wait states in both phases, error response
        hready_mode = 2;
        hready_val  = 1'b0;
        step(1'b1, 32'h20, 8'h5A, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        k = 0;
        while (HTRANS != 2'b10 && k < 20) begin
            step(1'b0, '0, '0, 1'b0);
            k++;
        end
        a0 = HADDR;
        s0 = HSIZE;
        chk("ws_first_addr", a0, 32'h20);
        repeat (3) begin
            step(1'b0, '0, '0, 1'b0);
            chk("ws_addr_hold", HADDR, a0);
            chk("ws_size_hold", {29'b0, HSIZE}, {29'b0, s0});
            chk("ws_trans_hold", {30'b0, HTRANS}, 32'd2);
        end
        hready_val = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        hready_val = 1'b0;
        d0 = HWDATA;
        chk("ws_data", d0, 32'h0000005A);
        repeat (3) begin
            step(1'b0, '0, '0, 1'b0);
            chk("ws_data_hold", HWDATA, d0);
            chk("ws_data_trans", {30'b0, HTRANS}, 32'd0);
        end
        hready_val = 1'b1;
        hresp_val  = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        hresp_val   = 1'b0;
        hready_mode = 0;
        drain("wait_states");
        chk("bus_error_model", {31'b0, bus_error}, {31'b0, exp_bus_error});
        chk("bus_error_set", {31'b0, bus_error}, 32'd1);

        // overflow: working register plus FIFO hold DEPTH+1 words
        hready_mode = 2;
        hready_val  = 1'b0;
        for (int w = 0; w < 6; w++)
            for (int b = 0; b < 4; b++)
                step(1'b1, 32'h100 + 32'(w * 4 + b), 8'($urandom), 1'b0);
        void'(exp_q.pop_back());
        step(1'b0, '0, '0, 1'b0);
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        chk("ovf_busy", {31'b0, busy}, 32'd1);
        hready_val = 1'b1;
        step(1'b0, '0, '0, 1'b0);
        hready_val = 1'b0;
        step(1'b0, '0, '0, 1'b0);
        reset_dut();
        chk("mid_rst_htrans", {30'b0, HTRANS}, 32'd0);
        chk("mid_rst_flags", {29'b0, busy, overflow, bus_error}, 32'd0);
        hready_mode = 0;
        repeat (4) step(1'b0, '0, '0, 1'b0);
        chk("mid_rst_quiet", {30'b0, HTRANS}, 32'd0);

        // randomized traffic with merges, flushes, timeouts and random waits
        for (int ph = 0; ph < 2; ph++) begin
            big_endian  = 1'(ph);
            hready_mode = 1;
            repeat (400) begin
                if (($urandom % 8) < 4 && exp_q.size() <= 2)
                    step(1'b1, 32'h200 + 32'($urandom_range(0, 15)), 8'($urandom), ($urandom % 16) == 0);
                else
                    step(1'b0, '0, '0, ($urandom % 24) == 0);
            end
            drain("random");
            chk("rand_overflow", {31'b0, overflow}, 32'd0);
            chk("rand_bus_error", {31'b0, bus_error}, {31'b0, exp_bus_error});
        end
        hready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
